// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, trap FSM states, machine CSR
// addresses/bit positions and trap cause encodings.
package core_pkg;

    localparam int unsigned Xlen = 32;

    typedef enum logic [1:0] {
        Idle  = 2'd0,
        Drain = 2'd1,
        Enter = 2'd2
    } trap_state_e;

    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMie     = 12'h304;
    localparam logic [11:0] CsrMip     = 12'h344;

    localparam int unsigned MieBit  = 3;
    localparam int unsigned MpieBit = 7;
    localparam int unsigned MsiBit  = 3;
    localparam int unsigned MtiBit  = 7;
    localparam int unsigned MeiBit  = 11;

    typedef enum logic [4:0] {
        IrqMsi = 5'd3,
        IrqMti = 5'd7,
        IrqMei = 5'd11
    } irq_code_e;

    typedef enum logic [4:0] {
        ExcInstrMisaligned = 5'd0,
        ExcInstrAccess     = 5'd1,
        ExcIllegalInstr    = 5'd2,
        ExcBreakpoint      = 5'd3,
        ExcLoadMisaligned  = 5'd4,
        ExcLoadAccess      = 5'd5,
        ExcStoreMisaligned = 5'd6,
        ExcStoreAccess     = 5'd7,
        ExcEcallU          = 5'd8,
        ExcEcallS          = 5'd9,
        ExcEcallM          = 5'd11
    } csr_mcause_e;

endpackage

// File: rtl/trap_ctrl_irq_prio_enc.sv
// Fixed-priority encoder for the enabled machine interrupts: ext > soft > timer.
module irq_prio_enc
    import core_pkg::*;
(
    input  logic       ext_i,
    input  logic       soft_i,
    input  logic       timer_i,
    output logic       valid_c,
    output logic [4:0] code_c
);

    always_comb begin
        valid_c = ext_i | soft_i | timer_i;
        code_c  = '0;
        if (ext_i) begin
            code_c = IrqMei;
        end else if (soft_i) begin
            code_c = IrqMsi;
        end else if (timer_i) begin
            code_c = IrqMti;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: owns MIE/MPIE, mie and mip, arbitrates
// exceptions against interrupts, drains before interrupts and sequences mret.
module trap_ctrl #(
    parameter int unsigned Xlen         = core_pkg::Xlen,
    parameter int unsigned DrainTimeout = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            irq_ext_i,
    input  logic            irq_soft_i,
    input  logic            irq_timer_i,
    input  logic            expt_valid_i,
    input  logic [4:0]      expt_cause_i,
    input  logic [Xlen-1:0] expt_pc_i,
    input  logic [Xlen-1:0] expt_tval_i,
    input  logic            mret_i,
    input  logic [Xlen-1:0] next_pc_i,
    input  logic            drain_done_i,
    output logic            flush_req_o,
    input  logic [Xlen-1:0] mtvec_i,
    input  logic [Xlen-1:0] mepc_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [Xlen-1:0] csr_wdata_i,
    output logic [Xlen-1:0] csr_rdata_o,
    output logic            csr_hit_o,
    output logic            trap_valid_o,
    output logic [Xlen-1:0] trap_cause_o,
    output logic [Xlen-1:0] trap_epc_o,
    output logic [Xlen-1:0] trap_tval_o,
    output logic            redirect_valid_o,
    output logic [Xlen-1:0] redirect_pc_o,
    output logic            drain_err_o
);
    import core_pkg::*;

    localparam int unsigned CntW = (DrainTimeout < 2) ? 1 : $clog2(DrainTimeout + 1);
    // RV32 keeps mepc word aligned (no compressed support assumed), RV64 halfword aligned.
    localparam logic [Xlen-1:0] EpcMask = (Xlen == 32) ? ~Xlen'(3) : ~Xlen'(1);

    trap_state_e     state_q, state_d;
    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic [2:0]      irq_en_q, irq_en_d;
    logic            lat_irq_q, lat_irq_d;
    logic [4:0]      lat_code_q, lat_code_d;
    logic [Xlen-1:0] lat_epc_q, lat_epc_d;
    logic [Xlen-1:0] lat_tval_q, lat_tval_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            drain_err_q, drain_err_d;

    logic            irq_valid_c;
    logic [4:0]      irq_code_c;
    logic            mret_take_c;
    logic            unused_wdata;

    assign unused_wdata = ^csr_wdata_i;

    irq_prio_enc u_prio (
        .ext_i   (irq_ext_i   & irq_en_q[2] & mie_q),
        .soft_i  (irq_soft_i  & irq_en_q[0] & mie_q),
        .timer_i (irq_timer_i & irq_en_q[1] & mie_q),
        .valid_c (irq_valid_c),
        .code_c  (irq_code_c)
    );

    assign mret_take_c = (state_q == Idle) && mret_i && !expt_valid_i && !irq_valid_c;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= Idle;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            irq_en_q    <= '0;
            lat_irq_q   <= 1'b0;
            lat_code_q  <= '0;
            lat_epc_q   <= '0;
            lat_tval_q  <= '0;
            cnt_q       <= '0;
            drain_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            irq_en_q    <= irq_en_d;
            lat_irq_q   <= lat_irq_d;
            lat_code_q  <= lat_code_d;
            lat_epc_q   <= lat_epc_d;
            lat_tval_q  <= lat_tval_d;
            cnt_q       <= cnt_d;
            drain_err_q <= drain_err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        mie_d            = mie_q;
        mpie_d           = mpie_q;
        irq_en_d         = irq_en_q;
        lat_irq_d        = lat_irq_q;
        lat_code_d       = lat_code_q;
        lat_epc_d        = lat_epc_q;
        lat_tval_d       = lat_tval_q;
        cnt_d            = '0;
        drain_err_d      = 1'b0;
        flush_req_o      = 1'b0;
        trap_valid_o     = 1'b0;
        trap_cause_o     = '0;
        trap_epc_o       = '0;
        trap_tval_o      = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;

        // CSR writes land first so a same-cycle trap entry or mret overrides MIE/MPIE.
        if (csr_we_i && csr_addr_i == CsrMie) begin
            irq_en_d = {csr_wdata_i[MeiBit], csr_wdata_i[MtiBit], csr_wdata_i[MsiBit]};
        end
        if (csr_we_i && csr_addr_i == CsrMstatus) begin
            mie_d  = csr_wdata_i[MieBit];
            mpie_d = csr_wdata_i[MpieBit];
        end

        case (state_q)
            Idle: begin
                if (expt_valid_i) begin
                    state_d    = Enter;
                    lat_irq_d  = 1'b0;
                    lat_code_d = expt_cause_i;
                    lat_epc_d  = expt_pc_i & EpcMask;
                    lat_tval_d = expt_tval_i;
                end else if (irq_valid_c) begin
                    state_d    = Drain;
                    lat_irq_d  = 1'b1;
                    lat_code_d = irq_code_c;
                    lat_epc_d  = '0;
                    lat_tval_d = '0;
                end else if (mret_i) begin
                    mie_d            = mpie_q;
                    mpie_d           = 1'b1;
                    redirect_valid_o = 1'b1;
                    redirect_pc_o    = mepc_i;
                end
            end
            Drain: begin
                flush_req_o = 1'b1;
                if (expt_valid_i) begin
                    state_d    = Enter;
                    lat_irq_d  = 1'b0;
                    lat_code_d = expt_cause_i;
                    lat_epc_d  = expt_pc_i & EpcMask;
                    lat_tval_d = expt_tval_i;
                end else if (drain_done_i) begin
                    state_d    = Enter;
                    lat_epc_d  = next_pc_i & EpcMask;
                    lat_tval_d = '0;
                end else if (DrainTimeout != 0 && cnt_q != CntW'(DrainTimeout)) begin
                    cnt_d       = cnt_q + CntW'(1);
                    drain_err_d = (cnt_q + CntW'(1)) == CntW'(DrainTimeout);
                end else begin
                    cnt_d = cnt_q;
                end
            end
            Enter: begin
                state_d          = Idle;
                mpie_d           = mie_q;
                mie_d            = 1'b0;
                trap_valid_o     = 1'b1;
                redirect_valid_o = 1'b1;
                trap_cause_o     = {lat_irq_q, {(Xlen-6){1'b0}}, lat_code_q};
                trap_epc_o       = lat_epc_q;
                trap_tval_o      = lat_tval_q;
                redirect_pc_o    = {mtvec_i[Xlen-1:2], 2'b00};
                if (lat_irq_q && mtvec_i[1:0] == 2'b01) begin
                    redirect_pc_o = {mtvec_i[Xlen-1:2], 2'b00} + Xlen'({lat_code_q, 2'b00});
                end
            end
            default: state_d = Idle;
        endcase
    end

    assign drain_err_o = drain_err_q;

    // mret_take_c mirrors the Idle mret branch; kept as a named qualifier for readability.
    logic unused_mret;
    assign unused_mret = mret_take_c;

    always_comb begin
        csr_rdata_o = '0;
        csr_hit_o   = 1'b0;
        case (csr_addr_i)
            CsrMstatus: begin
                csr_hit_o            = 1'b1;
                csr_rdata_o[MieBit]  = mie_q;
                csr_rdata_o[MpieBit] = mpie_q;
                csr_rdata_o[12:11]   = 2'b11;
            end
            CsrMie: begin
                csr_hit_o           = 1'b1;
                csr_rdata_o[MsiBit] = irq_en_q[0];
                csr_rdata_o[MtiBit] = irq_en_q[1];
                csr_rdata_o[MeiBit] = irq_en_q[2];
            end
            CsrMip: begin
                csr_hit_o           = 1'b1;
                csr_rdata_o[MsiBit] = irq_soft_i;
                csr_rdata_o[MtiBit] = irq_timer_i;
                csr_rdata_o[MeiBit] = irq_ext_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: CSR reads/writes, interrupt drain and entry,
// vectored redirect, exception preemption, mret and drain timeout.
module tb_trap_ctrl;

    localparam int unsigned Xlen = 32;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            irq_ext_i = 1'b0, irq_soft_i = 1'b0, irq_timer_i = 1'b0;
    logic            expt_valid_i = 1'b0;
    logic [4:0]      expt_cause_i = '0;
    logic [Xlen-1:0] expt_pc_i = '0, expt_tval_i = '0;
    logic            mret_i = 1'b0;
    logic [Xlen-1:0] next_pc_i = '0;
    logic            drain_done_i = 1'b0;
    logic            flush_req_o;
    logic [Xlen-1:0] mtvec_i = '0, mepc_i = '0;
    logic            csr_we_i = 1'b0;
    logic [11:0]     csr_addr_i = '0;
    logic [Xlen-1:0] csr_wdata_i = '0;
    logic [Xlen-1:0] csr_rdata_o;
    logic            csr_hit_o;
    logic            trap_valid_o;
    logic [Xlen-1:0] trap_cause_o, trap_epc_o, trap_tval_o;
    logic            redirect_valid_o;
    logic [Xlen-1:0] redirect_pc_o;
    logic            drain_err_o;

    int n_checks = 0;
    int n_errors = 0;

    trap_ctrl #(.Xlen(Xlen), .DrainTimeout(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .irq_ext_i(irq_ext_i), .irq_soft_i(irq_soft_i), .irq_timer_i(irq_timer_i),
        .expt_valid_i(expt_valid_i), .expt_cause_i(expt_cause_i),
        .expt_pc_i(expt_pc_i), .expt_tval_i(expt_tval_i),
        .mret_i(mret_i), .next_pc_i(next_pc_i), .drain_done_i(drain_done_i),
        .flush_req_o(flush_req_o), .mtvec_i(mtvec_i), .mepc_i(mepc_i),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o),
        .trap_valid_o(trap_valid_o), .trap_cause_o(trap_cause_o),
        .trap_epc_o(trap_epc_o), .trap_tval_o(trap_tval_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .drain_err_o(drain_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [Xlen-1:0] exp);
        csr_addr_i = addr;
        #1;
        check(tag, 64'(csr_rdata_o), 64'(exp));
    endtask

    task automatic wr(input logic [11:0] addr, input logic [Xlen-1:0] data);
        csr_we_i    = 1'b1;
        csr_addr_i  = addr;
        csr_wdata_i = data;
        step();
        csr_we_i    = 1'b0;
        csr_wdata_i = '0;
    endtask

    task automatic check_trap(input string tag, input logic [Xlen-1:0] cause,
                              input logic [Xlen-1:0] epc, input logic [Xlen-1:0] tval,
                              input logic [Xlen-1:0] rpc);
        check({tag, "_valid"}, 64'(trap_valid_o), 64'd1);
        check({tag, "_redir"}, 64'(redirect_valid_o), 64'd1);
        check({tag, "_cause"}, 64'(trap_cause_o), 64'(cause));
        check({tag, "_epc"}, 64'(trap_epc_o), 64'(epc));
        check({tag, "_tval"}, 64'(trap_tval_o), 64'(tval));
        check({tag, "_rpc"}, 64'(redirect_pc_o), 64'(rpc));
    endtask

    initial begin
        int errs;
        int flushes;

        // Reset state and CSR reset values
        step(); step();
        check("rst_trap_valid", 64'(trap_valid_o), 64'd0);
        check("rst_redirect", 64'(redirect_valid_o), 64'd0);
        check("rst_flush", 64'(flush_req_o), 64'd0);
        check("rst_drain_err", 64'(drain_err_o), 64'd0);
        check("rst_cause", 64'(trap_cause_o), 64'd0);
        rst_i = 1'b0;
        step();
        rd("rd_mstatus_rst", 12'h300, 32'h1800);
        check("hit_mstatus", 64'(csr_hit_o), 64'd1);
        rd("rd_mie_rst", 12'h304, 32'h0);
        rd("rd_mip_idle", 12'h344, 32'h0);
        rd("rd_other", 12'h305, 32'h0);
        check("hit_other", 64'(csr_hit_o), 64'd0);

        // mie write mask and mip reflection
        wr(12'h304, 32'hFFFF_FFFF);
        rd("rd_mie_mask", 12'h304, 32'h888);
        irq_soft_i = 1'b1; irq_timer_i = 1'b1;
        rd("rd_mip_lines", 12'h344, 32'h088);
        irq_soft_i = 1'b0; irq_timer_i = 1'b0;

        // External interrupt: three drain cycles, then trap entry
        wr(12'h304, 32'h800);
        wr(12'h300, 32'h8);
        rd("rd_mstatus_mie", 12'h300, 32'h1808);
        mtvec_i = 32'h200; next_pc_i = 32'h104;
        irq_ext_i = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("ext_flush%0d", k), 64'(flush_req_o), 64'd1);
            check($sformatf("ext_novalid%0d", k), 64'(trap_valid_o), 64'd0);
            if (k == 2) drain_done_i = 1'b1;
            step();
        end
        drain_done_i = 1'b0; irq_ext_i = 1'b0;
        #1;
        check_trap("ext", 32'h8000_000B, 32'h104, 32'h0, 32'h200);
        check("ext_flush_off", 64'(flush_req_o), 64'd0);
        step();
        check("ext_pulse_once", 64'(trap_valid_o), 64'd0);
        check("ext_redir_once", 64'(redirect_valid_o), 64'd0);
        rd("rd_mstatus_trap", 12'h300, 32'h1880);

        // Vectored timer interrupt
        wr(12'h304, 32'h080);
        wr(12'h300, 32'h8);
        mtvec_i = 32'h201; irq_timer_i = 1'b1;
        step();
        check("tmr_flush", 64'(flush_req_o), 64'd1);
        drain_done_i = 1'b1;
        step();
        drain_done_i = 1'b0; irq_timer_i = 1'b0;
        #1;
        check_trap("tmr", 32'h8000_0007, 32'h104, 32'h0, 32'h21C);
        step();

        // Exception preempts a draining ext interrupt; ext retaken afterwards
        wr(12'h304, 32'h800);
        wr(12'h300, 32'h8);
        irq_ext_i = 1'b1;
        step();
        check("pre_flush", 64'(flush_req_o), 64'd1);
        expt_valid_i = 1'b1; expt_cause_i = 5'd2; expt_pc_i = 32'h40; expt_tval_i = 32'hDEAD;
        step();
        expt_valid_i = 1'b0;
        #1;
        check_trap("exc", 32'h2, 32'h40, 32'hDEAD, 32'h200);
        step();
        step();
        check("exc_mie_off_noflush", 64'(flush_req_o), 64'd0);
        wr(12'h300, 32'h8);
        step();
        check("retake_flush", 64'(flush_req_o), 64'd1);
        drain_done_i = 1'b1;
        step();
        drain_done_i = 1'b0; irq_ext_i = 1'b0;
        #1;
        check_trap("retake", 32'h8000_000B, 32'h104, 32'h0, 32'h22C);
        step();

        // Ext and timer together: ext wins
        wr(12'h304, 32'h880);
        wr(12'h300, 32'h8);
        irq_ext_i = 1'b1; irq_timer_i = 1'b1; mtvec_i = 32'h200;
        step();
        drain_done_i = 1'b1;
        step();
        drain_done_i = 1'b0;
        #1;
        check_trap("both", 32'h8000_000B, 32'h104, 32'h0, 32'h200);
        step();
        // MIE=0 masks everything
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mie0_noflush%0d", k), 64'(flush_req_o), 64'd0);
            step();
        end
        // MIE=1 but mie=0 masks everything
        wr(12'h304, 32'h0);
        wr(12'h300, 32'h8);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("en0_noflush%0d", k), 64'(flush_req_o), 64'd0);
            step();
        end
        irq_ext_i = 1'b0; irq_timer_i = 1'b0;

        // Idle exception with misaligned PC: one-cycle latency, epc aligned
        mtvec_i = 32'h201;
        expt_valid_i = 1'b1; expt_cause_i = 5'd5; expt_pc_i = 32'h43; expt_tval_i = 32'h0;
        step();
        expt_valid_i = 1'b0;
        #1;
        check_trap("idle_exc", 32'h5, 32'h40, 32'h0, 32'h200);
        step();

        // mret: same-cycle redirect, MIE<=MPIE, MPIE<=1
        rd("rd_mstatus_pre_mret", 12'h300, 32'h1880);
        mepc_i = 32'h104; mret_i = 1'b1;
        #1;
        check("mret_redir", 64'(redirect_valid_o), 64'd1);
        check("mret_pc", 64'(redirect_pc_o), 64'h104);
        check("mret_no_trap", 64'(trap_valid_o), 64'd0);
        step();
        mret_i = 1'b0;
        #1;
        check("mret_redir_off", 64'(redirect_valid_o), 64'd0);
        rd("rd_mstatus_mret", 12'h300, 32'h1888);

        // Drain timeout: one drain_err pulse while drain_done is withheld
        wr(12'h304, 32'h800);
        mtvec_i = 32'h200; irq_ext_i = 1'b1;
        step();
        errs = 0; flushes = 0;
        for (int k = 0; k < 20; k++) begin
            errs += int'(drain_err_o);
            flushes += int'(flush_req_o);
            step();
        end
        check("to_err_pulses", 64'(errs), 64'd1);
        check("to_flush_cycles", 64'(flushes), 64'd20);
        drain_done_i = 1'b1;
        step();
        drain_done_i = 1'b0; irq_ext_i = 1'b0;
        #1;
        check_trap("to", 32'h8000_000B, 32'h104, 32'h0, 32'h200);
        step();
        check("to_err_quiet", 64'(drain_err_o), 64'd0);

        // Reset in the middle of a drain
        wr(12'h300, 32'h8);
        irq_ext_i = 1'b1;
        step();
        check("rstd_flush", 64'(flush_req_o), 64'd1);
        rst_i = 1'b1;
        step();
        check("rstd_flush_off", 64'(flush_req_o), 64'd0);
        check("rstd_no_trap", 64'(trap_valid_o), 64'd0);
        check("rstd_no_redir", 64'(redirect_valid_o), 64'd0);
        rst_i = 1'b0;
        step();
        check("rstd_idle", 64'(flush_req_o), 64'd0);
        rd("rd_mstatus_rstd", 12'h300, 32'h1800);
        irq_ext_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap sequencer in front of the CSR unit.
- Owns mstatus.MIE/MPIE, mie and mip. Arbitrates synchronous exceptions against the machine external, software and timer interrupts.
- Drains the pipeline before taking an interrupt, then issues a one-cycle trap-entry command: mepc/mcause/mtval writes plus a PC redirect.
- Also sequences mret return.

Parameters:
- Xlen, core_pkg::Xlen, datapath width (32 or 64).
- DrainTimeout, 16, cycles in Drain before drain_err_o pulses; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- irq_ext_i  in  1  machine external interrupt, level
- irq_soft_i  in  1  machine software interrupt, level
- irq_timer_i  in  1  machine timer interrupt, level
- expt_valid_i  in  1  committing instruction raised an exception
- expt_cause_i  in  5  exception code (core_pkg csr_mcause_e encoding)
- expt_pc_i  in  Xlen  PC of the faulting instruction
- expt_tval_i  in  Xlen  trap value
- mret_i  in  1  committing mret
- next_pc_i  in  Xlen  PC of the oldest uncommitted instruction
- drain_done_i  in  1  pipeline has no in-flight instructions
- flush_req_o  out  1  stop fetch and let the pipeline drain
- mtvec_i  in  Xlen  mtvec from the CSR unit
- mepc_i  in  Xlen  mepc from the CSR unit
- csr_we_i  in  1  CSR write strobe (already RW/RS/RC resolved)
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  Xlen  CSR write data
- csr_rdata_o  out  Xlen  read data for mstatus, mie and mip; '0 for all other addresses
- csr_hit_o  out  1  csr_addr_i is 0x300, 0x304 or 0x344
- trap_valid_o  out  1  trap-entry pulse
- trap_cause_o  out  Xlen  mcause value to write
- trap_epc_o  out  Xlen  mepc value to write
- trap_tval_o  out  Xlen  mtval value to write
- redirect_valid_o  out  1  PC redirect pulse (trap or mret)
- redirect_pc_o  out  Xlen  redirect target
- drain_err_o  out  1  drain timeout pulse

Behaviour:
- Reset:
  - state Idle; MIE=0, MPIE=0, mie=0; drain counter 0.
  - All pulse outputs 0; all data outputs '0.
- mstatus fields:
  - MIE is bit 3, MPIE is bit 7, MPP[12:11] reads 2'b11; all other bits read 0.
  - Writes update only MIE and MPIE.
- mie: only bits 3 (MSIE), 7 (MTIE) and 11 (MEIE) are writable; the rest read 0.
- mip: read-only. Bit 11 = irq_ext_i, bit 7 = irq_timer_i, bit 3 = irq_soft_i, sampled each cycle, no synchroniser.
- int_pend = mip & mie, qualified by MIE. Interrupt priority is ext > soft > timer.
- Idle:
  - expt_valid_i -> Enter next cycle, latching {cause, expt_pc_i, expt_tval_i}. No drain is performed; the pipeline is flushed by the redirect.
  - Otherwise int_pend != 0 -> Drain, latching the highest-priority interrupt code (11, 3 or 7).
  - Otherwise mret_i:
    - same cycle: redirect_valid_o=1, redirect_pc_o=mepc_i;
    - next cycle: MIE<=MPIE, MPIE<=1;
    - stay in Idle.
  - Priority when several occur together in Idle: expt > interrupt > mret. A losing mret is discarded; the pipeline refetches it.
- Drain:
  - flush_req_o=1; counter increments.
  - expt_valid_i -> Enter with the exception cause and PC. The exception replaces the latched interrupt; the interrupt is re-evaluated later.
  - drain_done_i -> Enter with trap_epc = next_pc_i sampled this cycle, tval=0.
  - Counter reaches DrainTimeout -> drain_err_o pulses once; stay in Drain.
  - The latched interrupt is taken even if its line deasserts during Drain.
- Enter (exactly 1 cycle), then Idle:
  - trap_valid_o=1, redirect_valid_o=1.
  - trap_cause_o: interrupt = {1'b1, zero-pad, code}; exception = {1'b0, zero-pad, code}.
  - trap_epc_o has bit 0 cleared (bits [1:0] cleared when Xlen=32).
  - redirect_pc_o = {mtvec_i[Xlen-1:2], 2'b00}. If mtvec_i[1:0]==1 and the trap is an interrupt, add 4*code.
  - Next cycle: MPIE<=MIE, MIE<=0.
- CSR write in the same cycle as Enter or mret: the MIE/MPIE update from the trap or mret wins; the mie write still applies.
- Latency:
  - exception -> redirect: 1 cycle;
  - interrupt -> redirect: 1 cycle after drain_done_i;
  - mret -> redirect: 0 cycles.
- Pulse rule: trap_valid_o and redirect_valid_o are never high two consecutive cycles from the trap path.
- Reset mid-Drain or mid-Enter: return to Idle, no pulse emitted.

Decomposition:
- core_pkg gains:
  - trap_state_e (Idle, Drain, Enter);
  - CSR address constants for mstatus/mie/mip;
  - bit-position constants MieBit=3, MpieBit=7, MsiBit=3, MtiBit=7, MeiBit=11;
  - interrupt code enum shared with csr.
- One sub-module: irq_prio_enc, combinational 3-input priority encoder producing {valid, code[4:0]}.

Test Plan:
- Reset, then read 0x300 -> 0x1800; read 0x304 and 0x344 with no irqs -> 0.
- Write mie=0x800, mstatus=0x8; assert irq_ext_i; drain_done_i 3 cycles later, next_pc_i=0x104, mtvec_i=0x200 -> flush_req_o for 3 cycles, then trap_cause_o=0x8000000B, trap_epc_o=0x104, redirect_pc_o=0x200; mstatus reads 0x1880.
- mtvec_i=0x201, timer interrupt enabled -> redirect_pc_o=0x21C.
- Exception code 2, pc=0x40, tval=0xDEAD while in Drain for an ext irq -> cause=0x2, epc=0x40, tval=0xDEAD; ext irq retaken after MIE is re-enabled.
- Ext and timer asserted together -> code 11 taken. With MIE=0 no trap occurs; with MIE=1 and mie=0 no trap occurs.
- mret with mepc_i=0x104, MPIE=1 -> same-cycle redirect to 0x104, mstatus reads 0x1888. drain_done_i withheld 16 cycles -> one drain_err_o pulse.
